// File: rtl/keypad_entry_controller.sv
// keypad_entry_controller: debounces one-hot keypad presses, strobes the BCD encoder once per press
// and shifts accepted digits into a 4-digit MM:SS time register.
module keypad_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key_dec_i,
    input  logic       entry_en_i,
    input  logic       clear_i,
    input  logic [3:0] enc_bcd_i,
    input  logic       enc_ai_i,
    output logic       enc_en_n_o,
    output logic [3:0] min_tens_o,
    output logic [3:0] min_units_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_units_o,
    output logic [2:0] digit_cnt_o,
    output logic       key_strobe_o,
    output logic       overflow_o,
    output logic       time_err_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, CAPTURE, WAIT_REL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    snap_q, snap_d;
    logic [15:0]   time_q, time_d;
    logic [2:0]    dcnt_q, dcnt_d;
    logic          strobe_q, strobe_d, ovf_q, ovf_d, terr_q;
    logic          onehot;

    assign onehot = (key_dec_i != 10'd0) && ((key_dec_i & (key_dec_i - 10'd1)) == 10'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        time_d   = time_q;
        dcnt_d   = dcnt_q;
        strobe_d = 1'b0;
        ovf_d    = 1'b0;
        case (state_q)
            IDLE: if (entry_en_i && onehot) begin
                snap_d  = key_dec_i;
                cnt_d   = '0;
                state_d = DEBOUNCE;
            end
            DEBOUNCE: if (key_dec_i != snap_q || !entry_en_i) state_d = IDLE;
                else if (cnt_q == LAST) state_d = CAPTURE;
                else cnt_d = cnt_q + 1'b1;
            CAPTURE: begin
                state_d = WAIT_REL;
                cnt_d   = '0;
                if (enc_ai_i && dcnt_q < 3'd4) begin
                    time_d   = {time_q[11:0], enc_bcd_i};
                    dcnt_d   = dcnt_q + 3'd1;
                    strobe_d = 1'b1;
                end else ovf_d = enc_ai_i;
            end
            default: if (!entry_en_i) state_d = IDLE;
                else if (key_dec_i != 10'd0) cnt_d = '0;
                else if (cnt_q == LAST) state_d = IDLE;
                else cnt_d = cnt_q + 1'b1;
        endcase
        // clear overrides everything, including a digit being captured this cycle
        if (clear_i) begin
            state_d  = IDLE;
            time_d   = '0;
            dcnt_d   = '0;
            strobe_d = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            snap_q   <= '0;
            time_q   <= '0;
            dcnt_q   <= '0;
            strobe_q <= 1'b0;
            ovf_q    <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            time_q   <= time_d;
            dcnt_q   <= dcnt_d;
            strobe_q <= strobe_d;
            ovf_q    <= ovf_d;
            terr_q   <= time_q[7:4] > 4'd5;
        end
    end

    assign enc_en_n_o   = state_q != CAPTURE;
    assign min_tens_o   = time_q[15:12];
    assign min_units_o  = time_q[11:8];
    assign sec_tens_o   = time_q[7:4];
    assign sec_units_o  = time_q[3:0];
    assign digit_cnt_o  = dcnt_q;
    assign key_strobe_o = strobe_q;
    assign overflow_o   = ovf_q;
    assign time_err_o   = terr_q;
endmodule

// File: tb/tb_keypad_entry_controller.sv
// tb_keypad_entry_controller: table-driven cycle vectors plus directed multi-cycle sequences,
// with a priority-encoder model standing in for the BCD encoder.
module tb_keypad_entry_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] key = '0;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] enc_bcd;
    logic       enc_ai;
    logic       enc_en_n, key_strobe, overflow, time_err;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic [2:0] digit_cnt;
    int         errors = 0;
    int         checks = 0;
    int         n_cap = 0, n_str = 0, n_ovf = 0;

    typedef struct {
        logic [9:0]  key;
        logic        en;
        logic        clr;
        logic [22:0] exp;
    } vec_t;

    // {enc_en_n, key_strobe, overflow, time_err, digit_cnt, MM:SS}
    localparam logic [22:0] I0   = 23'h400000;
    localparam logic [22:0] CAP0 = 23'h000000;
    localparam logic [22:0] STR7 = 23'h610007;
    localparam logic [22:0] HLD7 = 23'h410007;

    keypad_entry_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .key_dec_i(key), .entry_en_i(en), .clear_i(clr),
        .enc_bcd_i(enc_bcd), .enc_ai_i(enc_ai), .enc_en_n_o(enc_en_n),
        .min_tens_o(min_tens), .min_units_o(min_units), .sec_tens_o(sec_tens),
        .sec_units_o(sec_units), .digit_cnt_o(digit_cnt), .key_strobe_o(key_strobe),
        .overflow_o(overflow), .time_err_o(time_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        enc_bcd = 4'd0;
        for (int i = 0; i < 10; i++) if (key[i]) enc_bcd = 4'(i);
        enc_ai = |key;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (!enc_en_n) n_cap <= n_cap + 1;
            if (key_strobe) n_str <= n_str + 1;
            if (overflow) n_ovf <= n_ovf + 1;
        end
    end

    function automatic logic [22:0] outs();
        return {enc_en_n, key_strobe, overflow, time_err, digit_cnt,
                min_tens, min_units, sec_tens, sec_units};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic press(input logic [9:0] k);
        key = k;
        repeat (10) step();
        key = '0;
        repeat (6) step();
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        vec_t tbl[20];
        int c0, s0, o0;
        tbl = '{
            '{10'h080, 1'b1, 1'b0, I0},   '{10'h080, 1'b1, 1'b0, I0},
            '{10'h080, 1'b1, 1'b0, I0},   '{10'h080, 1'b1, 1'b0, I0},
            '{10'h080, 1'b1, 1'b0, CAP0}, '{10'h080, 1'b1, 1'b0, STR7},
            '{10'h080, 1'b1, 1'b0, HLD7}, '{10'h080, 1'b1, 1'b0, HLD7},
            '{10'h080, 1'b1, 1'b0, HLD7}, '{10'h080, 1'b1, 1'b0, HLD7},
            '{10'h000, 1'b1, 1'b0, HLD7}, '{10'h000, 1'b1, 1'b0, HLD7},
            '{10'h000, 1'b1, 1'b0, HLD7}, '{10'h000, 1'b1, 1'b0, HLD7},
            '{10'h014, 1'b1, 1'b0, HLD7}, '{10'h014, 1'b1, 1'b0, HLD7},
            '{10'h014, 1'b1, 1'b0, HLD7}, '{10'h014, 1'b1, 1'b0, HLD7},
            '{10'h014, 1'b1, 1'b0, HLD7}, '{10'h014, 1'b1, 1'b0, HLD7}
        };
        repeat (2) step();
        chk("reset", outs(), I0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key = tbl[i].key;
            en  = tbl[i].en;
            clr = tbl[i].clr;
            step();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        key = '0;
        step();

        pulse_clear();
        chk("clear", outs(), I0);
        s0 = n_str; o0 = n_ovf;
        press(10'h002); press(10'h004); press(10'h008); press(10'h001);
        chk("time_1230", outs(), 23'h441230);
        chk("strobes_4", 23'(n_str - s0), 23'd4);
        s0 = n_str;
        press(10'h020);
        chk("ovf_digits", outs(), 23'h441230);
        chk("ovf_pulse", 23'(n_ovf - o0), 23'd1);
        chk("ovf_no_strobe", 23'(n_str - s0), 23'd0);

        pulse_clear();
        c0 = n_cap;
        repeat (3) begin
            key = 10'h008;
            repeat (2) step();
            key = '0;
            step();
        end
        chk("bounce_none", 23'(n_cap - c0), 23'd0);
        press(10'h008);
        chk("bounce_one", 23'(n_cap - c0), 23'd1);
        chk("bounce_digit", outs(), 23'h410003);

        c0 = n_cap;
        key = 10'h004;
        repeat (2) step();
        key = 10'h014;
        repeat (8) step();
        key = '0;
        repeat (6) step();
        chk("join_abort", 23'(n_cap - c0), 23'd0);

        pulse_clear();
        press(10'h200);
        key = 10'h001;
        repeat (6) step();
        chk("err_edge", outs(), 23'h620090);
        step();
        chk("err_set", 23'(time_err), 23'd1);
        key = '0;
        repeat (6) step();
        pulse_clear();
        chk("err_clear_digits", {16'd0, digit_cnt, min_tens, min_units, sec_tens, sec_units}, 23'd0);
        step();
        chk("err_cleared", 23'(time_err), 23'd0);

        press(10'h010);
        c0 = n_cap; s0 = n_str;
        key = 10'h080;
        repeat (2) step();
        en = 1'b0;
        repeat (6) step();
        key = '0;
        repeat (2) step();
        en = 1'b1;
        repeat (2) step();
        chk("en_drop_cap", 23'(n_cap - c0), 23'd0);
        chk("en_drop_keep", outs(), 23'h410004);

        s0 = n_str;
        key = 10'h020;
        repeat (5) step();
        chk("in_capture", 23'(enc_en_n), 23'd0);
        clr = 1'b1;
        key = '0;
        step();
        clr = 1'b0;
        chk("clear_wins", outs(), I0);
        repeat (3) step();
        chk("clear_no_strobe", 23'(n_str - s0), 23'd0);

        press(10'h040);
        key = 10'h080;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rst_mid", outs(), I0);
        rst = 1'b0;
        key = '0;
        repeat (3) step();
        chk("rst_idle", outs(), I0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
